conv_par_ser: RTL and testbench
===============================

CONV_PAR_SER -- requirements
Module: conv_par_ser

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning input FIFO depth in words (legal 1..8).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port d  input  8  parallel word to transmit.
REQ-005 The block SHALL have port load  input  1  write strobe; word accepted on a posedge when load && ready.
REQ-006 The block SHALL have port ready  output  1  FIFO not full; combinational from registered occupancy.
REQ-007 The block SHALL have port out  output  1  registered serial line; idles high, feeds the negedge-sampling serial-to-parallel receiver.
REQ-008 The block SHALL have port busy  output  1  high while FIFO non-empty or FSM not IDLE.

Function
REQ-009 The frame SHALL be: start bit (out=0) for one cycle, then d[7]..d[0] MSB first, one cycle each.
REQ-010 out SHALL change only on posedge clk, so the downstream receiver samples each bit mid-cycle on negedge.
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP; STOP exists only with the macro (REQ-024).
REQ-012 IDLE: out=1; if the FIFO is non-empty, pop the head into an 8-bit shift register, go to START, and drive out=0 at that same edge.
REQ-013 START lasts one cycle; the next edge drives out=shreg[7] and enters DATA with bit counter 0.
REQ-014 DATA: each edge shifts left and increments the 3-bit counter; after 8 data cycles (counter wraps 7->0), the next state SHALL be STOP if present, else START when the FIFO is non-empty (popping at that edge), else IDLE.
REQ-015 Latency: a word written at edge k into an empty FIFO with the FSM in IDLE SHALL drive the start bit from edge k+1, and bit d[7] from edge k+2.
REQ-016 A push and a pop at the same edge SHALL both take effect, leaving occupancy unchanged.
REQ-017 load while ready=0 SHALL be ignored; the word is dropped and the FIFO is unchanged.
REQ-018 A pop at the same edge as the push of the only word SHALL NOT occur; the FSM sees that word one edge later, per REQ-015.
REQ-019 Changes on d after acceptance SHALL NOT affect a queued or in-flight frame.

Reset
REQ-020 While rst is sampled high, the block SHALL force out=1, state=IDLE, counter=0, shift register=0, and FIFO occupancy=0 (all contents discarded).
REQ-021 After reset, outputs SHALL be ready=1 and busy=0.
REQ-022 Reset during a frame SHALL truncate that frame immediately; the line returns high and no partial frame resumes.
REQ-023 rst SHALL take priority over load in the same cycle.

Configuration
REQ-024 When macro CONV_PAR_SER_STOP_EN is defined, the block SHALL append one STOP cycle (out=1) after d[0], giving a 10-cycle frame period.
REQ-025 When CONV_PAR_SER_STOP_EN is undefined, back-to-back frames SHALL be contiguous, giving a 9-cycle frame period.

Structure
REQ-026 Shared package conv_ser_pkg SHALL hold the FSM state enum, FRAME_BITS=8 and the START_LVL=0 and IDLE_LVL=1 constants, for reuse by the receiver side.
REQ-027 The FIFO SHALL be a sub-module conv_fifo with parameters WIDTH and DEPTH, synchronous reset, and push/pop/full/empty/count ports.

Verification
REQ-028 The bench SHALL check: reset, then load d=8'hA5 once -> out from edge k+1 is 0,1,0,1,0,0,1,0,1, then idle 1; busy falls after the last bit (plus STOP when the macro is enabled).
REQ-029 The bench SHALL check: load 8'h00 then 8'hFF on consecutive cycles -> both frames sent; without the macro the second start bit directly follows the first frame's d[0], and a loopback receiver reports 00 then FF.
REQ-030 The bench SHALL check: DEPTH=2, hold load high for 4 cycles while a frame is in flight -> ready drops once full, excess words are dropped, and exactly the accepted words appear on out in order.
REQ-031 The bench SHALL check: assert rst for 1 cycle at data bit 4 of 8'h3C -> out=1 at the next edge, busy=0, ready=1, and no further frame without a new load.
REQ-032 The bench SHALL check: with CONV_PAR_SER_STOP_EN, send two queued words -> start-to-start spacing is exactly 10 cycles (9 without the macro).
REQ-033 The bench SHALL check: change d to 8'h55 one cycle after loading 8'hC3 -> the transmitted frame is C3.

Source files
------------

// File: rtl/conv_ser_pkg.sv
// Shared definitions for the parallel-to-serial transmitter and its matching
// serial-to-parallel receiver.
//
// Optional feature macro: CONV_PAR_SER_STOP_EN. When it is defined, the state
// enum gains a STOP state.
//
// Contents:
//   conv_state_e  transmitter FSM state encoding
//   FRAME_BITS    data bits per frame
//   CNT_W         width of the data-bit counter
//   START_LVL     line level of the start bit
//   IDLE_LVL      line level between frames (and of the STOP bit)
package conv_ser_pkg;

  localparam int FRAME_BITS = 8;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic START_LVL = 1'b0;
  localparam logic IDLE_LVL  = 1'b1;

`ifdef CONV_PAR_SER_STOP_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } conv_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2
  } conv_state_e;
`endif

endpackage

// File: rtl/conv_fifo.sv
// Small synchronous FIFO that queues parallel words ahead of the serializer.
//
// Ports:
//   clk    in   clock; all state updates on posedge
//   rst    in   synchronous active-high reset; empties the FIFO
//   push   in   write wdata (ignored when full)
//   wdata  in   [WIDTH-1:0] word to write
//   pop    in   drop the head word (ignored when empty)
//   rdata  out  [WIDTH-1:0] head word, valid while !empty
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
//   count  out  [CW-1:0] current occupancy
module conv_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    // simultaneous push and pop leave occupancy unchanged
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/conv_par_ser.sv
// Parallel-to-serial transmitter. Words written through a small FIFO are sent
// as: start bit (0), d[7]..d[0] MSB first, optional STOP bit (1). The line is
// registered and only changes on posedge, so a receiver sampling on negedge
// sees each bit mid-cycle.
//
// Optional feature macro: CONV_PAR_SER_STOP_EN appends one STOP cycle (line
// high) after d[0], giving a 10-cycle frame period instead of 9.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset; truncates any frame
//   d      in   [7:0] word to transmit
//   load   in   write strobe; word taken on posedge when load && ready
//   ready  out  FIFO not full
//   out    out  registered serial line, idles high
//   busy   out  FIFO non-empty or FSM not IDLE
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit on the line, word held in the shift register
// DATA   | data bits on the line, counter counts 0..7
// STOP   | stop bit on the line (only with CONV_PAR_SER_STOP_EN)
module conv_par_ser
  import conv_ser_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_BITS-1:0] d,
  input  logic                  load,
  output logic                  ready,
  output logic                  out,
  output logic                  busy
);

  localparam int CW = $clog2(DEPTH + 1);

  conv_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  out_q, out_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [FRAME_BITS-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_cnt;

  assign ready     = !fifo_full;
  assign fifo_push = load && ready;
  assign busy      = (fifo_cnt != '0) || (state_q != ST_IDLE);
  assign out       = out_q;

  conv_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (d),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    out_d    = out_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        out_d = IDLE_LVL;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          out_d    = START_LVL;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        out_d   = shreg_q[FRAME_BITS-1];
        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
        cnt_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
`ifdef CONV_PAR_SER_STOP_EN
          out_d   = IDLE_LVL;
          state_d = ST_STOP;
`else
          // back-to-back: next start bit directly follows d[0]
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_rdata;
            out_d    = START_LVL;
            state_d  = ST_START;
          end else begin
            out_d   = IDLE_LVL;
            state_d = ST_IDLE;
          end
`endif
        end else begin
          out_d   = shreg_q[FRAME_BITS-1];
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
        end
      end
`ifdef CONV_PAR_SER_STOP_EN
      ST_STOP: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          out_d    = START_LVL;
          state_d  = ST_START;
        end else begin
          out_d   = IDLE_LVL;
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        out_d   = IDLE_LVL;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      out_q   <= IDLE_LVL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_conv_par_ser.sv
// Directed self-checking bench for conv_par_ser (DEPTH=2). A negedge-sampling
// receiver decodes the line so frame contents and order can be checked.
module tb_conv_par_ser;

`ifdef CONV_PAR_SER_STOP_EN
  localparam int PERIOD = 10;
`else
  localparam int PERIOD = 9;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       load;
  logic       ready;
  logic       ser;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;

  conv_par_ser #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .load  (load),
    .ready (ready),
    .out   (ser),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // loopback receiver: samples mid-bit on negedge
  logic [7:0] rx_sh;
  int         rx_n;
  bit         rx_act = 1'b0;
  logic [7:0] rx_q [$];

  always @(negedge clk) begin
    if (rst) begin
      rx_act = 1'b0;
      rx_n   = 0;
    end else if (rx_act) begin
      rx_sh = {rx_sh[6:0], ser};
      rx_n++;
      if (rx_n == 8) begin
        rx_q.push_back(rx_sh);
        rx_act = 1'b0;
      end
    end else if (ser === 1'b0) begin
      rx_act = 1'b1;
      rx_n   = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w);
    d    = w;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(n >= 300), 32'd0);
    step();
  endtask

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  initial begin
    logic [8:0] wv;
    logic       line [24];
    int         s0, s1, zeros;

    rst  = 1'b1;
    load = 1'b0;
    d    = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_out", 32'(ser), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // single A5 frame, edge k = load edge
    rx_q = {};
    wv = 9'b0_1010_0101;
    load_word(8'hA5);
    chk("a5_k_out", 32'(ser), 32'd1);
    chk("a5_k_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("a5_bit%0d", i), 32'(ser), 32'(wv[8-i]));
    end
    chk("a5_busy_last", 32'(busy), 32'd1);
    step();
    chk("a5_idle_out", 32'(ser), 32'd1);
`ifdef CONV_PAR_SER_STOP_EN
    chk("a5_stop_busy", 32'(busy), 32'd1);
    step();
    chk("a5_idle_out2", 32'(ser), 32'd1);
`endif
    chk("a5_busy_fall", 32'(busy), 32'd0);
    step();

    // 00 then FF on consecutive cycles
    rx_q = {};
    d    = 8'h00;
    load = 1'b1;
    step();
    d = 8'hFF;
    step();
    load = 1'b0;
    chk("b2b_f0_start", 32'(ser), 32'd0);
    repeat (9) step();
`ifdef CONV_PAR_SER_STOP_EN
    chk("b2b_stop", 32'(ser), 32'd1);
    step();
`endif
    chk("b2b_f1_start", 32'(ser), 32'd0);
    step();
    chk("b2b_f1_d7", 32'(ser), 32'd1);
    wait_idle();
    chk("b2b_rx_n", 32'(rx_q.size()), 32'd2);
    chk("b2b_rx0", 32'(rx_at(0)), 32'h00);
    chk("b2b_rx1", 32'(rx_at(1)), 32'hFF);

    // overflow while a frame is in flight
    rx_q = {};
    load_word(8'h11);
    repeat (2) step();
    load = 1'b1;
    d    = 8'h21;
    step();
    chk("ovf_rdy1", 32'(ready), 32'd1);
    d = 8'h32;
    step();
    chk("ovf_rdy2", 32'(ready), 32'd0);
    d = 8'h43;
    step();
    chk("ovf_rdy3", 32'(ready), 32'd0);
    d = 8'h54;
    step();
    load = 1'b0;
    chk("ovf_rdy4", 32'(ready), 32'd0);
    wait_idle();
    chk("ovf_rx_n", 32'(rx_q.size()), 32'd3);
    chk("ovf_rx0", 32'(rx_at(0)), 32'h11);
    chk("ovf_rx1", 32'(rx_at(1)), 32'h21);
    chk("ovf_rx2", 32'(rx_at(2)), 32'h32);
    chk("ovf_ready_end", 32'(ready), 32'd1);

    // reset in the middle of 3C
    rx_q = {};
    load_word(8'h3C);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("trunc_out", 32'(ser), 32'd1);
    chk("trunc_busy", 32'(busy), 32'd0);
    chk("trunc_ready", 32'(ready), 32'd1);
    zeros = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ser !== 1'b1) zeros++;
    end
    chk("trunc_no_resume", 32'(zeros), 32'd0);
    chk("trunc_busy2", 32'(busy), 32'd0);
    chk("trunc_rx_n", 32'(rx_q.size()), 32'd0);

    // reset wins over load
    rst  = 1'b1;
    load = 1'b1;
    d    = 8'h99;
    step();
    rst  = 1'b0;
    load = 1'b0;
    chk("prio_busy", 32'(busy), 32'd0);
    step();
    chk("prio_out", 32'(ser), 32'd1);
    chk("prio_busy2", 32'(busy), 32'd0);

    // start-to-start spacing for two queued words
    rx_q = {};
    d    = 8'h81;
    load = 1'b1;
    step();
    d = 8'h7E;
    step();
    load = 1'b0;
    for (int i = 0; i < 24; i++) begin
      line[i] = ser;
      step();
    end
    s0 = -1;
    s1 = -1;
    for (int i = 0; i < 24; i++) begin
      if (s0 < 0 && line[i] === 1'b0) s0 = i;
    end
    for (int i = 0; i < 24; i++) begin
      if (s0 >= 0 && s1 < 0 && i >= s0 + 9 && line[i] === 1'b0) s1 = i;
    end
    chk("sp_first_start", 32'(s0), 32'd0);
    chk("sp_spacing", 32'(s1 - s0), 32'(PERIOD));
    wait_idle();
    chk("sp_rx0", 32'(rx_at(0)), 32'h81);
    chk("sp_rx1", 32'(rx_at(1)), 32'h7E);

    // d changes right after acceptance
    rx_q = {};
    load_word(8'hC3);
    d = 8'h55;
    wait_idle();
    chk("hold_rx_n", 32'(rx_q.size()), 32'd1);
    chk("hold_rx0", 32'(rx_at(0)), 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
